sync_pair_aligner: RTL and testbench
====================================

SYNC_PAIR_ALIGNER -- requirements
Module: sync_pair_aligner

Interface
REQ-001 The block SHALL have these parameters: XW, 10, coordinate width; DEPTH, 8, pending-queue depth (power of two, 2..64).
REQ-002 Port list (clock and reset first):
- clk_25  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- q  in  2*XW+24  FIFO word {x, y, r8, g8, b8}
- rdempty  in  1  FIFO empty
- rdclk  out  1  equals clk_25
- rdreq  out  1  FIFO read request
- query_x, query_y  out  XW each  coordinate sent to the homography unit
- start  out  1  one-cycle query strobe
- ready  in  1  homography result strobe
- return_x, return_y  in  XW each  coordinate echoed with the result
- r, g, b  in  5/6/5  homography pixel
- flush  in  1  stop fetching and drain
- val  out  1  one-cycle output strobe
- sync_x, sync_y  out  XW each  aligned coordinate
- dvi_r, dvi_g, dvi_b  out  5/6/5  FIFO pixel, truncated
- ccd_r, ccd_g, ccd_b  out  5/6/5  homography pixel
- pending  out  log2(DEPTH)+1  queue occupancy
- underflow  out  1  sticky: ready arrived with the queue empty
- debug  out  1  sticky: coordinate mismatch (see REQ-021)
REQ-003 Clocking and reset SHALL be: one clock, clk_25; reset rst is asynchronous and active-high.

Function
REQ-004 States SHALL be S_IDLE, S_RUN and S_DRAIN.
REQ-005 Transitions SHALL be:
- S_IDLE->S_RUN when rdempty=0 and flush=0.
- S_RUN->S_DRAIN when flush=1.
- S_DRAIN->S_IDLE when pending=0, no read is in flight, and flush=0.
- S_DRAIN holds while flush=1.
REQ-006 rdreq SHALL be registered and asserted only in S_RUN, when rdempty=0 and pending + in-flight reads < DEPTH.
REQ-007 The q word SHALL be sampled in the cycle after rdreq=1 (non-show-ahead FIFO); at most 2 reads SHALL be in flight.
REQ-008 When q is sampled, {x, y, r[7:3], g[7:2], b[7:3]} SHALL be pushed to the tail of the pending queue.
REQ-009 In the cycle after that push, query_x and query_y SHALL carry x and y, and start SHALL pulse for one cycle; query_x and query_y otherwise hold their last value.
REQ-010 Latency SHALL be: rdreq at cycle t gives start at t+2.
REQ-011 When ready=1 and the queue is non-empty, the head entry SHALL be popped.
REQ-012 At the pop cycle u+1: val=1 for one cycle; sync_x, sync_y and dvi_* come from the popped entry; ccd_* come from r/g/b as sampled at u.
REQ-013 sync_*, dvi_* and ccd_* SHALL hold their value between val pulses.
REQ-014 A simultaneous push and pop in one cycle SHALL leave pending unchanged, with both operations performed.
REQ-015 ready=1 with pending=0 and no push in the same cycle SHALL cause no pop and no val, and SHALL set underflow.
REQ-016 A push with pending=DEPTH SHALL be impossible by REQ-006; the bench SHALL assert this.
REQ-017 Queue read and write pointers SHALL wrap modulo DEPTH.
REQ-018 pending SHALL be registered and SHALL reflect the occupancy after the current cycle's push and pop.
REQ-019 rdclk SHALL be a direct assignment of clk_25.

Reset
REQ-020 On rst=1 all of the following SHALL be 0 immediately, asynchronously: state=S_IDLE, pointers, pending, rdreq, start, val, query_*, sync_*, dvi_*, ccd_*, underflow, debug. Reset mid-operation SHALL discard queue contents and in-flight reads.

Configuration
REQ-021 Macro SYNC_COORD_CHECK_EN:
- Defined: on each pop, return_x and return_y are compared with the head entry's x and y; any difference sets debug (sticky until reset).
- Undefined: no comparator is built, and debug SHALL be tied to 0.

Verification
REQ-022 Single pixel, q={10'd5, 10'd7, 8'hF8, 8'hFC, 8'hF8}, rdempty low for one read: start at t+2 with query=(5,7); ready at u gives val at u+1 with sync=(5,7), dvi=(31,63,31), ccd equal to the r/g/b sampled at u.
REQ-023 Backpressure, DEPTH=8, ready held low: exactly 8 pushes, then rdreq stays 0 and pending=8; one ready pulse gives exactly one more rdreq.
REQ-024 Simultaneous push/pop with pending=3: pending stays 3, and output order is first-in first-out across 20 entries with pointer wrap.
REQ-025 ready pulse with pending=0: val stays 0 and underflow=1 until reset.
REQ-026 With SYNC_COORD_CHECK_EN, return_x = head x + 1: debug=1 and stays 1; without the macro, debug=0.
REQ-027 flush asserted with 4 pending: no further rdreq; after 4 ready pulses, pending=0; state S_DRAIN->S_IDLE once flush falls. rst pulsed mid-stream: all outputs are 0 in the same cycle.

Source files
------------

// File: rtl/sync_pair_aligner.sv
// sync_pair_aligner: pairs FIFO pixels with in-order homography results; optional mismatch flag via SYNC_COORD_CHECK_EN.
module sync_pair_aligner #(
  parameter int XW = 10,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk_25,
  input  logic            rst,
  input  logic [2*XW+23:0] q,
  input  logic            rdempty,
  output logic            rdclk,
  output logic            rdreq,
  output logic [XW-1:0]   query_x,
  output logic [XW-1:0]   query_y,
  output logic            start,
  input  logic            ready,
  input  logic [XW-1:0]   return_x,
  input  logic [XW-1:0]   return_y,
  input  logic [4:0]      r,
  input  logic [5:0]      g,
  input  logic [4:0]      b,
  input  logic            flush,
  output logic            val,
  output logic [XW-1:0]   sync_x,
  output logic [XW-1:0]   sync_y,
  output logic [4:0]      dvi_r,
  output logic [5:0]      dvi_g,
  output logic [4:0]      dvi_b,
  output logic [4:0]      ccd_r,
  output logic [5:0]      ccd_g,
  output logic [4:0]      ccd_b,
  output logic [AW:0]     pending,
  output logic            underflow,
  output logic            debug
);
  localparam int EW = 2*XW+16;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t state_q, state_d;
  logic rdreq_q, rdreq_d, rd1_q, start_q, val_q, und_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] pend_q, pend_d;
  logic [XW-1:0] qx_q, qy_q, sx_q, sy_q;
  logic [4:0] dr_q, db_q, cr_q, cb_q;
  logic [5:0] dg_q, cg_q;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] in_e, head;
  logic push, pop;
  assign rdclk = clk_25;
  assign in_e = {q[2*XW+23 -: 2*XW], q[23:19], q[15:10], q[7:3]};
  assign push = rd1_q;
  // an empty queue pops the entry arriving this cycle directly
  assign head = (pend_q == '0) ? in_e : mem[rd_q];
  assign pop = ready && (pend_q != '0 || push);
  assign pend_d = pend_q + (AW+1)'(push) - (AW+1)'(pop);
  // reserve room for the read still in the FIFO pipeline
  assign rdreq_d = state_q == S_RUN && !flush && !rdempty &&
                   ({1'b0, pend_d} + (AW+2)'(rdreq_q) < (AW+2)'(DEPTH));
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = (!rdempty && !flush) ? S_RUN : S_IDLE;
      S_RUN:   state_d = flush ? S_DRAIN : S_RUN;
      S_DRAIN: state_d = (!flush && pend_q == '0 && !rdreq_q && !rd1_q) ? S_IDLE : S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_25) if (push) mem[wr_q] <= in_e;
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdreq_q <= 1'b0;
      rd1_q <= 1'b0;
      start_q <= 1'b0;
      val_q <= 1'b0;
      und_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      pend_q <= '0;
      qx_q <= '0;
      qy_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      dr_q <= '0;
      dg_q <= '0;
      db_q <= '0;
      cr_q <= '0;
      cg_q <= '0;
      cb_q <= '0;
    end else begin
      state_q <= state_d;
      rdreq_q <= rdreq_d;
      rd1_q <= rdreq_q;
      start_q <= push;
      val_q <= pop;
      pend_q <= pend_d;
      if (push) begin
        wr_q <= wr_q + 1'b1;
        qx_q <= in_e[EW-1 -: XW];
        qy_q <= in_e[EW-XW-1 -: XW];
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
        sx_q <= head[EW-1 -: XW];
        sy_q <= head[EW-XW-1 -: XW];
        dr_q <= head[15:11];
        dg_q <= head[10:5];
        db_q <= head[4:0];
        cr_q <= r;
        cg_q <= g;
        cb_q <= b;
      end
      if (ready && !pop) und_q <= 1'b1;
    end
  end
`ifdef SYNC_COORD_CHECK_EN
  logic dbg_q;
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) dbg_q <= 1'b0;
    else if (pop && (return_x != head[EW-1 -: XW] || return_y != head[EW-XW-1 -: XW])) dbg_q <= 1'b1;
  end
  assign debug = dbg_q;
  logic unused_bits;
  assign unused_bits = ^{q[18:16], q[9:8], q[2:0]};
`else
  assign debug = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{q[18:16], q[9:8], q[2:0], return_x, return_y};
`endif
  assign rdreq = rdreq_q;
  assign start = start_q;
  assign query_x = qx_q;
  assign query_y = qy_q;
  assign val = val_q;
  assign sync_x = sx_q;
  assign sync_y = sy_q;
  assign dvi_r = dr_q;
  assign dvi_g = dg_q;
  assign dvi_b = db_q;
  assign ccd_r = cr_q;
  assign ccd_g = cg_q;
  assign ccd_b = cb_q;
  assign pending = pend_q;
  assign underflow = und_q;
endmodule

// File: tb/tb_sync_pair_aligner.sv
// tb_sync_pair_aligner: directed bench with a FIFO model and an in-order scoreboard of expected entries.
module tb_sync_pair_aligner;
  localparam int XW = 10;
  localparam int DEPTH = 8;
`ifdef SYNC_COORD_CHECK_EN
  localparam logic DBG_EXP = 1'b1;
`else
  localparam logic DBG_EXP = 1'b0;
`endif
  logic clk_25, rst, rdempty, rdclk, rdreq, start, ready, flush, val, underflow, debug;
  logic [43:0] q;
  logic [9:0] query_x, query_y, return_x, return_y, sync_x, sync_y;
  logic [4:0] r, b, dvi_r, dvi_b, ccd_r, ccd_b;
  logic [5:0] g, dvi_g, ccd_g;
  logic [3:0] pending;
  logic [43:0] word_mem [64];
  logic [43:0] exp_w [$];
  int wr_idx = 0, rd_idx = 0, rdreq_cnt = 0, ovf_bad = 0;
  int pass_n = 0, total_n = 0;
  logic served = 1'b0;
  int n0;
  sync_pair_aligner #(.XW(XW), .DEPTH(DEPTH)) dut (
    .clk_25(clk_25), .rst(rst), .q(q), .rdempty(rdempty), .rdclk(rdclk), .rdreq(rdreq),
    .query_x(query_x), .query_y(query_y), .start(start), .ready(ready),
    .return_x(return_x), .return_y(return_y), .r(r), .g(g), .b(b), .flush(flush),
    .val(val), .sync_x(sync_x), .sync_y(sync_y), .dvi_r(dvi_r), .dvi_g(dvi_g), .dvi_b(dvi_b),
    .ccd_r(ccd_r), .ccd_g(ccd_g), .ccd_b(ccd_b), .pending(pending),
    .underflow(underflow), .debug(debug));
  initial clk_25 = 1'b0;
  always #5 clk_25 = ~clk_25;
  // FIFO model: the empty flag already accounts for a read that has been requested
  assign rdempty = (rd_idx + (rdreq ? 1 : 0)) >= wr_idx;
  always @(posedge clk_25) begin
    if (served && pending == 4'(DEPTH)) ovf_bad <= ovf_bad + 1;
    served <= rdreq;
    if (rdreq) begin
      q <= word_mem[rd_idx];
      rd_idx <= rd_idx + 1;
    end
  end
  always @(posedge clk_25) if (rdreq) rdreq_cnt <= rdreq_cnt + 1;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk_25);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic load(input logic [43:0] w);
    word_mem[wr_idx] = w;
    exp_w.push_back(w);
    wr_idx++;
  endtask
  function automatic logic [43:0] mk(input logic [9:0] x);
    logic [7:0] c;
    c = x[7:0];
    return {x, x + 10'd1, c, ~c, c ^ 8'h5A};
  endfunction
  task automatic wait_rdreq(input string tag);
    int n;
    n = 0;
    while (!rdreq && n < 10) begin
      tick;
      n++;
    end
    chk(tag, rdreq, 1);
  endtask
  task automatic pop_chk(input string tag, input logic [9:0] bump);
    logic [43:0] w;
    w = exp_w[0];
    ready = 1'b1;
    return_x = w[43:34] + bump;
    return_y = w[33:24];
    tick;
    ready = 1'b0;
    chk({tag, "_val"}, val, 1);
    chk({tag, "_x"}, sync_x, w[43:34]);
    chk({tag, "_y"}, sync_y, w[33:24]);
    void'(exp_w.pop_front());
  endtask
  initial begin
    rst = 1'b1; ready = 1'b0; flush = 1'b0; q = '0;
    return_x = '0; return_y = '0; r = '0; g = '0; b = '0;
    #2;
    chk("rst_rdreq", rdreq, 0);
    chk("rst_start", start, 0);
    chk("rst_val", val, 0);
    chk("rst_pending", pending, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_debug", debug, 0);
    chk("rst_sync_x", sync_x, 0);
    tick; tick;
    rst = 1'b0;
    tick; tick;
    chk("idle_state", dut.state_q, 0);
    // single pixel latency and field mapping
    load({10'd5, 10'd7, 8'hF8, 8'hFC, 8'hF8});
    wait_rdreq("t1_rdreq");
    tick;
    chk("t1_start_early", start, 0);
    tick;
    chk("t1_start", start, 1);
    chk("t1_query_x", query_x, 5);
    chk("t1_query_y", query_y, 7);
    chk("t1_pending", pending, 1);
    tick;
    chk("t1_start_once", start, 0);
    chk("t1_query_hold", query_x, 5);
    r = 5'h12; g = 6'h2A; b = 5'h09;
    pop_chk("t1_pop", 0);
    chk("t1_dvi_r", dvi_r, 31);
    chk("t1_dvi_g", dvi_g, 63);
    chk("t1_dvi_b", dvi_b, 31);
    chk("t1_ccd_r", ccd_r, 5'h12);
    chk("t1_ccd_g", ccd_g, 6'h2A);
    chk("t1_ccd_b", ccd_b, 5'h09);
    chk("t1_pending0", pending, 0);
    r = 5'h01; g = 6'h01; b = 5'h01;
    tick;
    chk("t1_val_once", val, 0);
    chk("t1_ccd_hold", ccd_r, 5'h12);
    chk("t1_sync_hold", sync_x, 5);
    chk("t1_no_underflow", underflow, 0);
    // ready with empty queue
    ready = 1'b1;
    tick;
    ready = 1'b0;
    chk("uf_val", val, 0);
    chk("uf_flag", underflow, 1);
    chk("uf_pending", pending, 0);
    tick;
    chk("uf_sticky", underflow, 1);
    // simultaneous push/pop at pending 3 with pointer wrap
    for (int i = 0; i < 3; i++) load(mk(10'(300 + i)));
    repeat (8) tick;
    chk("pp_prefill", pending, 3);
    for (int i = 0; i < 20; i++) begin
      load(mk(10'(400 + i)));
      wait_rdreq("pp_rdreq");
      tick;
      pop_chk("pp_pop", 0);
      chk("pp_pending", pending, 3);
      chk("pp_start", start, 1);
    end
    for (int i = 0; i < 3; i++) pop_chk("pp_drain", 0);
    chk("pp_empty", pending, 0);
    // backpressure
    n0 = rdreq_cnt;
    for (int i = 0; i < 9; i++) load(mk(10'(500 + i)));
    repeat (20) tick;
    chk("bp_reads", rdreq_cnt - n0, 8);
    chk("bp_pending", pending, 8);
    chk("bp_rdreq_low", rdreq, 0);
    n0 = rdreq_cnt;
    pop_chk("bp_pop", 0);
    repeat (10) tick;
    chk("bp_one_more", rdreq_cnt - n0, 1);
    chk("bp_pending_full", pending, 8);
    // coordinate check and flush drain
    pop_chk("dbg_pop", 1);
    chk("dbg_flag", debug, DBG_EXP);
    for (int i = 0; i < 3; i++) pop_chk("fl_pre", 0);
    chk("fl_pending4", pending, 4);
    flush = 1'b1;
    n0 = rdreq_cnt;
    tick;
    chk("fl_drain_state", dut.state_q, 2);
    load(mk(10'd600));
    load(mk(10'd601));
    repeat (5) tick;
    chk("fl_no_rdreq", rdreq_cnt - n0, 0);
    for (int i = 0; i < 4; i++) pop_chk("fl_pop", 0);
    chk("fl_pending0", pending, 0);
    chk("fl_hold_drain", dut.state_q, 2);
    chk("dbg_sticky", debug, DBG_EXP);
    chk("uf_still", underflow, 1);
    flush = 1'b0;
    tick;
    chk("fl_idle", dut.state_q, 0);
    tick;
    chk("fl_run", dut.state_q, 1);
    tick;
    chk("fl_resume", rdreq, 1);
    tick; tick;
    chk("rs_pending", pending, 1);
    chk("rs_start", start, 1);
    pop_chk("rs_pop", 0);
    // asynchronous reset mid-stream
    #2 rst = 1'b1;
    #1;
    chk("ar_rdreq", rdreq, 0);
    chk("ar_start", start, 0);
    chk("ar_val", val, 0);
    chk("ar_pending", pending, 0);
    chk("ar_query_x", query_x, 0);
    chk("ar_query_y", query_y, 0);
    chk("ar_sync_x", sync_x, 0);
    chk("ar_sync_y", sync_y, 0);
    chk("ar_dvi_r", dvi_r, 0);
    chk("ar_dvi_g", dvi_g, 0);
    chk("ar_ccd_r", ccd_r, 0);
    chk("ar_ccd_b", ccd_b, 0);
    chk("ar_underflow", underflow, 0);
    chk("ar_debug", debug, 0);
    chk("ar_state", dut.state_q, 0);
    chk("no_push_when_full", ovf_bad, 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
